// File: rtl/lab4_cpu_rx_status_pio.sv
// Avalon-MM input PIO with 2-flop synchronizer, edge capture and maskable IRQ.
// Optional define LAB4_PIO_BIT_CLEAR_EN: per-bit write-to-clear of edge_cap.
module lab4_cpu_rx_status_pio #(
    parameter int               WIDTH      = 1,
    parameter int               EDGE_TYPE  = 0,
    parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] wd;
    logic             wr;
    logic             wr_mask;
    logic             wr_cap;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wr_mask   = wr && (address == 2'd2);
    assign wr_cap    = wr && (address == 2'd3);
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Select which transitions of the synchronized input count as edges
    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0)
            edge_det = sync2 & ~prev;
        else if (EDGE_TYPE == 1)
            edge_det = ~sync2 & prev;
        else
            edge_det = sync2 ^ prev;
    end

    // Bits of edge_cap cleared by a CPU write this cycle
    always_comb begin
        clr = '0;
        if (wr_cap) begin
`ifdef LAB4_PIO_BIT_CLEAR_EN
            clr = wd;
`else
            clr = '1;
`endif
        end
    end

    // Synchronizer chain and previous-value register for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Edge capture: a new edge wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            edge_cap <= '0;
        else
            edge_cap <= (edge_cap & ~clr) | edge_det;
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq_mask <= RESET_MASK;
        else if (wr_mask)
            irq_mask <= wd;
    end

    // Registered level interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= |(edge_cap & irq_mask);
    end

    // Zero-latency read mux, zero-extended to 32 bits
    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0:    readdata[WIDTH-1:0] = sync2;
            2'd1:    readdata = '0;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_cap;
            default: readdata = '0;
        endcase
    end

endmodule
